// File: rtl/divsqrt_arbiter.sv
// divsqrt_arbiter: round-robin front end that shares one divide/sqrt unit among NREQ requesters.
// Ports: req/req_op/req_opa/req_opb in; grant/ack/resp_* out; unit_* handshake to the shared unit.
module divsqrt_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_opa,
  input  logic [NREQ*WIDTH-1:0] req_opb,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_error,
  output logic                  resp_timeout,
  output logic                  unit_start,
  output logic                  unit_op,
  output logic [WIDTH-1:0]      unit_opa,
  output logic [WIDTH-1:0]      unit_opb,
  output logic                  unit_abort,
  input  logic                  unit_done,
  input  logic                  unit_error,
  input  logic [WIDTH-1:0]      unit_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gidx;
  logic [CW-1:0]   wd_cnt;

  logic [IW-1:0]   sel_idx;
  logic [IW:0]     cand;
  logic            sel_op;
  logic [WIDTH-1:0] sel_opa;
  logic [WIDTH-1:0] sel_opb;
  logic            wd_expire;

  // Walk from the farthest candidate back to rr_ptr so the
  // nearest set bit at or above rr_ptr is the last to win.
  always_comb begin
    sel_idx = '0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ))
        cand = cand - (IW+1)'(NREQ);
      if (req[cand[IW-1:0]])
        sel_idx = cand[IW-1:0];
    end
  end

  always_comb begin
    sel_op  = 1'b0;
    sel_opa = '0;
    sel_opb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == IW'(i)) begin
        sel_op  = req_op[i];
        sel_opa = req_opa[i*WIDTH +: WIDTH];
        sel_opb = req_opb[i*WIDTH +: WIDTH];
      end
    end
  end

  // The abort must land in the expiring WAIT cycle itself, and a
  // coincident done takes priority, hence the combinational path.
  assign wd_expire = (state == WAIT) &&
                     (wd_cnt == CW'(TIMEOUT - 1)) &&
                     !unit_done;
  assign unit_abort = wd_expire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gidx         <= '0;
      wd_cnt       <= '0;
      grant        <= '0;
      ack          <= '0;
      unit_start   <= 1'b0;
      unit_op      <= 1'b0;
      unit_opa     <= '0;
      unit_opb     <= '0;
      resp_result  <= '0;
      resp_error   <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      unit_start <= 1'b0;
      ack        <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant      <= NREQ'(1) << sel_idx;
            gidx       <= sel_idx;
            unit_op    <= sel_op;
            unit_opa   <= sel_opa;
            unit_opb   <= sel_opb;
            unit_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (unit_done) begin
            resp_result  <= unit_result;
            resp_error   <= unit_error;
            resp_timeout <= 1'b0;
            ack          <= grant;
            state        <= RESP;
          end else if (wd_expire) begin
            resp_result  <= '0;
            resp_error   <= 1'b1;
            resp_timeout <= 1'b1;
            ack          <= grant;
            state        <= RESP;
          end
        end
        RESP: begin
          if (gidx == IW'(NREQ - 1))
            rr_ptr <= '0;
          else
            rr_ptr <= gidx + 1'b1;
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divsqrt_arbiter.sv
// tb_divsqrt_arbiter: randomized bench with a behavioural unit model
// and a round-robin reference for divsqrt_arbiter.
module tb_divsqrt_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int TO = 64;

  logic clk = 0;
  logic reset_n = 0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_op = '0;
  logic [N*W-1:0] req_opa = '0;
  logic [N*W-1:0] req_opb = '0;
  logic [N-1:0] grant, ack;
  logic [W-1:0] resp_result;
  logic resp_error, resp_timeout;
  logic unit_start, unit_op, unit_abort;
  logic [W-1:0] unit_opa, unit_opb;
  logic unit_done = 0;
  logic unit_error = 0;
  logic [W-1:0] unit_result = '0;

  always #5 clk = ~clk;

  divsqrt_arbiter #(.NREQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req(req), .req_op(req_op),
    .req_opa(req_opa), .req_opb(req_opb),
    .grant(grant), .ack(ack),
    .resp_result(resp_result),
    .resp_error(resp_error),
    .resp_timeout(resp_timeout),
    .unit_start(unit_start), .unit_op(unit_op),
    .unit_opa(unit_opa), .unit_opb(unit_opb),
    .unit_abort(unit_abort),
    .unit_done(unit_done), .unit_error(unit_error),
    .unit_result(unit_result)
  );

  typedef struct {
    logic [N-1:0] gr;
    logic op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int cyc;
  } st_t;

  typedef struct {
    logic [N-1:0] ak;
    logic [N-1:0] gr;
    logic [W-1:0] res;
    logic err;
    logic tmo;
    int cyc;
  } ak_t;

  st_t sq[$];
  ak_t aq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int m_lat = 10;
  bit m_rand = 0;
  bit m_err = 0;
  bit m_hang = 0;
  bit m_inject = 0;
  bit m_busy = 0;
  int m_rem = 0;
  logic m_op = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  int done_cyc = -1;
  int abort_cnt = 0;
  int abort_cyc = -1;

  function automatic logic [W-1:0] unit_fn(
    input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op) return $realtobits($sqrt($bitstoreal(a)));
    return $realtobits($bitstoreal(a) / $bitstoreal(b));
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  // Unit model drives at the falling edge, the monitor samples 1ns later.
  always begin
    @(negedge clk);
    unit_done = 0;
    unit_error = 0;
    if (!reset_n) m_busy = 0;
    if (m_inject) begin
      unit_done = 1;
      unit_result = '1;
      m_inject = 0;
    end else if (m_busy && !m_hang) begin
      m_rem--;
      if (m_rem <= 0) begin
        unit_done = 1;
        unit_error = m_err;
        unit_result = unit_fn(m_op, m_a, m_b);
        m_busy = 0;
        done_cyc = cyc;
      end
    end
    if (unit_start) begin
      m_busy = 1;
      m_op = unit_op;
      m_a = unit_opa;
      m_b = unit_opb;
      if (m_rand) m_rem = int'($urandom_range(3, 15));
      else m_rem = unit_op ? 14 : m_lat;
    end
    #1;
    if (unit_start)
      sq.push_back('{grant, unit_op, unit_opa, unit_opb, cyc});
    if (ack != 0)
      aq.push_back('{ack, grant, resp_result,
                     resp_error, resp_timeout, cyc});
    if (unit_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
      m_busy = 0;
    end
  end

  task automatic set_req(input int i, input logic op,
                         input real a, input real b);
    req_op[i] = op;
    req_opa[i*W +: W] = $realtobits(a);
    req_opb[i*W +: W] = $realtobits(b);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset_n = 0;
    req = '0;
    m_hang = 0;
    m_err = 0;
    m_rand = 0;
    m_inject = 0;
    m_lat = 10;
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1;
    sq.delete();
    aq.delete();
    abort_cnt = 0;
    abort_cyc = -1;
  endtask

  task automatic run_until(input int n, input int budget,
                           input bit drop, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #2;
      if (drop && ack != 0) req &= ~ack;
      if (aq.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #2;
    reset_n = 0;
    #1;
    checks++;
    if ({grant, ack} !== '0) begin
      errors++;
      $display("FAIL reset_grant_ack: got %b want 0", {grant, ack});
    end
    checks++;
    if ({unit_start, unit_abort, unit_op} !== 3'b000) begin
      errors++;
      $display("FAIL reset_unit_ctl: got %b want 000",
               {unit_start, unit_abort, unit_op});
    end
    checks++;
    if ({resp_result, resp_error, resp_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_resp: got %h/%b/%b want 0",
               resp_result, resp_error, resp_timeout);
    end
    checks++;
    if ({unit_opa, unit_opb} !== '0) begin
      errors++;
      $display("FAIL reset_operands: got %h %h want 0",
               unit_opa, unit_opb);
    end
    do_reset();
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (sq.size() != 0 || grant !== '0) begin
      errors++;
      $display("FAIL idle_no_req: starts %0d grant %b want 0/0",
               sq.size(), grant);
    end
  endtask

  task automatic test_single_divide();
    bit ok;
    int r_cyc;
    do_reset();
    set_req(0, 1'b0, 6.0, 2.0);
    @(negedge clk); #2;
    req = 4'b0001;
    r_cyc = cyc;
    @(negedge clk); #2;
    checks++;
    if (grant !== 4'b0001 || unit_start !== 1'b1) begin
      errors++;
      $display("FAIL div_grant: got %b start %b want 0001 1",
               grant, unit_start);
    end
    run_until(1, 100, 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL div_ack_wait: got no ack want ack");
    end else begin
      checks++;
      if (aq[0].ak !== 4'b0001 || aq[0].gr !== 4'b0001) begin
        errors++;
        $display("FAIL div_ack: got %b grant %b want 0001",
                 aq[0].ak, aq[0].gr);
      end
      checks++;
      if (aq[0].cyc != done_cyc + 1 || aq[0].cyc - r_cyc != 12) begin
        errors++;
        $display("FAIL div_latency: got ack@%0d done@%0d req@%0d want done+1, req+12",
                 aq[0].cyc, done_cyc, r_cyc);
      end
      checks++;
      if (aq[0].res !== $realtobits(3.0) || aq[0].err !== 1'b0) begin
        errors++;
        $display("FAIL div_result: got %h err %b want %h err 0",
                 aq[0].res, aq[0].err, $realtobits(3.0));
      end
    end
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (aq.size() != 1 || sq.size() != 1 || grant !== '0) begin
      errors++;
      $display("FAIL div_single_pulse: got acks %0d starts %0d grant %b want 1 1 0",
               aq.size(), sq.size(), grant);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int ptr;
    int e;
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 1'($urandom_range(0, 1)),
              real'($urandom_range(1, 10000)),
              real'($urandom_range(1, 500)));
    m_rand = 1;
    @(negedge clk); #2;
    req = 4'b1111;
    run_until(8, 400, 0, ok);
    req = '0;
    checks++;
    if (!ok || sq.size() != 8) begin
      errors++;
      $display("FAIL rr_count: got acks %0d starts %0d want 8 8",
               aq.size(), sq.size());
    end else begin
      ptr = 0;
      for (int k = 0; k < 8; k++) begin
        e = rr_pick(4'b1111, ptr);
        checks++;
        if (aq[k].ak !== (N'(1) << e) || aq[k].gr !== aq[k].ak) begin
          errors++;
          $display("FAIL rr_order[%0d]: got ack %b grant %b want %b",
                   k, aq[k].ak, aq[k].gr, N'(1) << e);
        end
        checks++;
        if (sq[k].op !== req_op[e] ||
            sq[k].a !== req_opa[e*W +: W] ||
            sq[k].b !== req_opb[e*W +: W]) begin
          errors++;
          $display("FAIL rr_operands[%0d]: got op %b a %h want op %b a %h",
                   k, sq[k].op, sq[k].a, req_op[e], req_opa[e*W +: W]);
        end
        checks++;
        if (aq[k].res !== unit_fn(req_op[e], req_opa[e*W +: W],
                                  req_opb[e*W +: W])) begin
          errors++;
          $display("FAIL rr_result[%0d]: got %h want %h", k, aq[k].res,
                   unit_fn(req_op[e], req_opa[e*W +: W], req_opb[e*W +: W]));
        end
        ptr = (e + 1) % N;
      end
    end
    repeat (5) @(negedge clk);
    #2;
    checks++;
    if (sq.size() != 8 || aq.size() != 8) begin
      errors++;
      $display("FAIL rr_no_extra: got starts %0d acks %0d want 8 8",
               sq.size(), aq.size());
    end
    m_rand = 0;
  endtask

  task automatic test_mixed_ops();
    bit ok;
    int e;
    do_reset();
    set_req(1, 1'b0, 9.0, 3.0);
    set_req(2, 1'b1, 16.0, 0.0);
    @(negedge clk); #2;
    req = 4'b0110;
    run_until(2, 200, 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mix_wait: got %0d acks want 2", aq.size());
    end else begin
      e = rr_pick(4'b0110, 0);
      checks++;
      if (aq[0].ak !== (N'(1) << e) || sq[0].op !== 1'b0 ||
          aq[0].res !== $realtobits(3.0)) begin
        errors++;
        $display("FAIL mix_first: got ack %b op %b res %h want %b 0 %h",
                 aq[0].ak, sq[0].op, aq[0].res, N'(1) << e,
                 $realtobits(3.0));
      end
      e = rr_pick(4'b0100, (e + 1) % N);
      checks++;
      if (aq[1].ak !== (N'(1) << e) || sq[1].op !== 1'b1 ||
          aq[1].res !== $realtobits(4.0)) begin
        errors++;
        $display("FAIL mix_second: got ack %b op %b res %h want %b 1 %h",
                 aq[1].ak, sq[1].op, aq[1].res, N'(1) << e,
                 $realtobits(4.0));
      end
    end
  endtask

  task automatic test_error_passthrough();
    bit ok;
    do_reset();
    m_err = 1;
    set_req(3, 1'b0, 8.0, 2.0);
    @(negedge clk); #2;
    req = 4'b1000;
    run_until(1, 100, 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL err_wait: got no ack want ack");
    end else begin
      checks++;
      if (aq[0].err !== 1'b1 || aq[0].tmo !== 1'b0 ||
          aq[0].ak !== 4'b1000 || abort_cnt != 0) begin
        errors++;
        $display("FAIL err_flags: got err %b tmo %b ack %b aborts %0d want 1 0 1000 0",
                 aq[0].err, aq[0].tmo, aq[0].ak, abort_cnt);
      end
    end
    m_err = 0;
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    m_hang = 1;
    set_req(0, 1'b1, 25.0, 1.0);
    @(negedge clk); #2;
    req = 4'b0001;
    run_until(1, 200, 1, ok);
    checks++;
    if (!ok || sq.size() != 1) begin
      errors++;
      $display("FAIL tmo_wait: got acks %0d starts %0d want 1 1",
               aq.size(), sq.size());
    end else begin
      checks++;
      if (abort_cnt != 1 || abort_cyc != sq[0].cyc + TO) begin
        errors++;
        $display("FAIL tmo_abort: got %0d pulses @%0d want 1 @%0d",
                 abort_cnt, abort_cyc, sq[0].cyc + TO);
      end
      checks++;
      if (aq[0].cyc != abort_cyc + 1 || aq[0].err !== 1'b1 ||
          aq[0].tmo !== 1'b1) begin
        errors++;
        $display("FAIL tmo_ack: got @%0d err %b tmo %b want @%0d 1 1",
                 aq[0].cyc, aq[0].err, aq[0].tmo, abort_cyc + 1);
      end
    end
    m_hang = 0;
    m_inject = 1;
    repeat (6) @(negedge clk);
    #2;
    checks++;
    if (aq.size() != 1 || sq.size() != 1 || grant !== '0 ||
        abort_cnt != 1) begin
      errors++;
      $display("FAIL stale_done: got acks %0d starts %0d grant %b aborts %0d want 1 1 0 1",
               aq.size(), sq.size(), grant, abort_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    set_req(1, 1'b0, 10.0, 4.0);
    @(negedge clk); #2;
    req = 4'b0010;
    run_until(1, 100, 1, ok);
    m_hang = 1;
    set_req(2, 1'b0, 7.0, 7.0);
    req = 4'b0100;
    repeat (6) @(negedge clk);
    #2;
    checks++;
    if (sq.size() != 2 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL rst_setup: got starts %0d grant %b want 2 0100",
               sq.size(), grant);
    end
    reset_n = 0;
    req = '0;
    #1;
    checks++;
    if ({grant, ack, unit_start, unit_abort, unit_op} !== '0 ||
        {resp_result, resp_error, resp_timeout} !== '0 ||
        {unit_opa, unit_opb} !== '0) begin
      errors++;
      $display("FAIL rst_outputs: got grant %b ack %b opa %h res %h want 0",
               grant, ack, unit_opa, resp_result);
    end
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1;
    m_hang = 0;
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (aq.size() != 1) begin
      errors++;
      $display("FAIL rst_no_ack: got %0d acks want 1", aq.size());
    end
    set_req(3, 1'b0, 12.0, 3.0);
    req = 4'b1010;
    run_until(3, 200, 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_resume: got %0d acks want 3", aq.size());
    end else begin
      checks++;
      if (aq[1].ak !== (N'(1) << rr_pick(4'b1010, 0))) begin
        errors++;
        $display("FAIL rst_rr_ptr: got %b want %b", aq[1].ak,
                 N'(1) << rr_pick(4'b1010, 0));
      end
      checks++;
      if (aq[2].ak !== 4'b1000 || aq[2].res !== $realtobits(4.0)) begin
        errors++;
        $display("FAIL rst_req3: got %b res %h want 1000 %h",
                 aq[2].ak, aq[2].res, $realtobits(4.0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_divide();
    test_round_robin();
    test_mixed_ops();
    test_error_passthrough();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench time limit");
  end

endmodule
